rd_sched_block: RTL

- Sequences read-check traffic for the compare datapath. Accepts read-check commands from the test FSM and issues one Avalon-MM burst read per command.
- Hands each command's compare packet to the compare block exactly once, ahead of that burst's readdata.
- Limits packets in flight to 2, the compare block's one storage slot plus one in-process packet, and drains cleanly on error stop.

---
 rtl/rd_sched_block.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/rd_sched_block.sv
// Read-check scheduler: issues one Avalon-MM burst read per accepted command and
// strobes the command to the compare block one cycle before that burst's read.
package settings_pkg;
   localparam int unsigned CMP_ADDR_W  = 31;
   localparam int unsigned CMP_BURST_W = 11;

   typedef struct packed {
      logic [CMP_ADDR_W-1:0]  word_addr;
      logic [CMP_BURST_W-1:0] word_count;
      logic [31:0]            mask;
      logic [31:0]            pattern;
   } cmp_struct_t;
endpackage

module rd_sched_block #(
   parameter int unsigned ADDR_W   = 31,
   parameter int unsigned BURST_W  = 11,
   parameter int unsigned MAX_PKTS = 2
) (
   input  logic                      clk_i,
   input  logic                      rst_n_i,
   input  logic                      start_test_i,
   input  logic                      error_check_i,
   input  logic                      cmd_valid_i,
   output logic                      cmd_ready_o,
   input  settings_pkg::cmp_struct_t cmd_pkt_i,
   output logic                      cmp_pkt_en_o,
   output settings_pkg::cmp_struct_t cmp_pkt_o,
   output logic                      amm_read_o,
   output logic [ADDR_W-1:0]         amm_address_o,
   output logic [BURST_W-1:0]        amm_burstcount_o,
   input  logic                      amm_waitrequest_i,
   input  logic                      amm_readdatavalid_i,
   output logic                      busy_o
);

   typedef enum logic [1:0] {IDLE, LOAD, ISSUE, DRAIN} state_t;

   state_t             state;
   state_t             state_nx;
   logic [1:0]         pkt_cnt;
   logic [1:0]         pkt_cnt_nx;
   logic               stop_flg;
   logic               stop_nx;
   logic [15:0]        rem_cnt;
   logic [15:0]        rem_nx;
   logic [BURST_W-1:0] fifo [2];
   logic               wr_ptr;
   logic               rd_ptr;
   logic               accept;
   logic               push;
   logic               pop;

   function automatic logic [15:0] ext(input logic [BURST_W-1:0] wc);
      return 16'(wc);
   endfunction

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) state <= IDLE;
      else          state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: begin
            if (stop_flg && (pkt_cnt != 2'd0))
               state_nx = DRAIN;
            else if (accept && (cmd_pkt_i.word_count != '0))
               state_nx = LOAD;
         end
         LOAD:  state_nx = ISSUE;
         ISSUE: begin
            if (!amm_waitrequest_i)
               state_nx = stop_flg ? DRAIN : IDLE;
         end
         DRAIN: begin
            if (pkt_cnt == 2'd0)
               state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      cmp_pkt_en_o = (state == LOAD);
      amm_read_o   = (state == ISSUE);
   end

   always_comb begin
      accept = cmd_ready_o && cmd_valid_i;
      push   = (state == LOAD);
      pop    = amm_readdatavalid_i && (pkt_cnt != 2'd0) && (rem_cnt == 16'd1);

      stop_nx = stop_flg;
      if (start_test_i)       stop_nx = 1'b0;
      else if (error_check_i) stop_nx = 1'b1;

      pkt_cnt_nx = pkt_cnt;
      if (push && !pop)      pkt_cnt_nx = pkt_cnt + 2'd1;
      else if (pop && !push) pkt_cnt_nx = pkt_cnt - 2'd1;

      // rem_cnt always tracks the oldest outstanding burst; a pop hands over to
      // the queued entry, or to the burst being pushed when the queue empties.
      rem_nx = rem_cnt;
      if (pop) begin
         if (pkt_cnt == 2'd2) rem_nx = ext(fifo[~rd_ptr]);
         else if (push)       rem_nx = ext(cmp_pkt_o.word_count);
         else                 rem_nx = '0;
      end else if (push && (pkt_cnt == 2'd0)) begin
         rem_nx = ext(cmp_pkt_o.word_count);
      end else if (amm_readdatavalid_i && (pkt_cnt != 2'd0)) begin
         rem_nx = rem_cnt - 16'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         stop_flg         <= 1'b0;
         pkt_cnt          <= '0;
         rem_cnt          <= '0;
         wr_ptr           <= 1'b0;
         rd_ptr           <= 1'b0;
         cmp_pkt_o        <= '0;
         amm_address_o    <= '0;
         amm_burstcount_o <= '0;
         cmd_ready_o      <= 1'b0;
         busy_o           <= 1'b0;
      end else begin
         stop_flg <= stop_nx;
         pkt_cnt  <= pkt_cnt_nx;
         rem_cnt  <= rem_nx;
         if (push) wr_ptr <= ~wr_ptr;
         if (pop)  rd_ptr <= ~rd_ptr;
         if (accept && (cmd_pkt_i.word_count != '0))
            cmp_pkt_o <= cmd_pkt_i;
         if (state == LOAD) begin
            amm_address_o    <= cmp_pkt_o.word_addr;
            amm_burstcount_o <= cmp_pkt_o.word_count;
         end
         // Decoded from next-state values so both flags are clean flop outputs.
         cmd_ready_o <= (state_nx == IDLE) && (32'(pkt_cnt_nx) < MAX_PKTS) && !stop_nx;
         busy_o      <= (state_nx != IDLE) || (pkt_cnt_nx != 2'd0);
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) fifo[wr_ptr] <= cmp_pkt_o.word_count;
   end

endmodule
